seq_scan_ctrl: RTL and testbench

Sequencing controller for the team's serial pattern detectors, such as seq_det, the Mealy detector for 101/110. It accepts a parallel word over a valid/ready handshake and clears the attached detector before each word. It then streams the word MSB-first into the detector, one bit per clock, counts the detector's hit pulses and returns the hit count and first-hit position over a second valid/ready handshake. It sits between a parallel producer and any single-bit, free-running detector that has no enable.

---
 rtl/seq_scan_ctrl_if.sv | 28 ++
 rtl/seq_scan_ctrl.sv | 97 +++++++++
 tb/tb_seq_scan_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: handshake bundle for seq_scan_ctrl.
//   s_valid/s_ready/s_data           : parallel word in (producer -> controller)
//   m_valid/m_ready/m_count/m_first/m_none : scan result out (controller -> consumer)
// slave  : controller view.
// master : producer/consumer (environment) view.
interface seq_scan_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_count;
  logic [CNT_W-1:0] m_first;
  logic             m_none;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_count, m_first, m_none
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_count, m_first, m_none
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts a word, clears the attached serial detector, streams the word
// MSB-first into it one bit per clock, counts hit pulses and reports count / first-hit index.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : seq_scan_ctrl_if.slave (input word handshake + result handshake)
//   det_clr   : hold-in-idle to the detector, high in every state except SHIFT
//   det_bit   : serial bit to the detector
//   det_hit   : detector's combinational Mealy output for the current det_bit
module seq_scan_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_scan_ctrl_if.slave        bus,
  output logic                  det_clr,
  output logic                  det_bit,
  input  logic                  det_hit
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic               seen_q, seen_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      first_q <= first_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    count_d = count_q;
    first_d = first_q;
    seen_d  = seen_q;
    unique case (state_q)
      StIdle: begin
        if (bus.s_valid) begin
          shreg_d = bus.s_data;
          idx_d   = '0;
          count_d = '0;
          first_d = '0;
          seen_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (det_hit) begin
          count_d = count_q + 1'b1;
          if (!seen_q) begin
            first_d = idx_q;
            seen_d  = 1'b1;
          end
        end
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        idx_d   = idx_q + 1'b1;
        // Last bit's hit is counted in this same cycle before leaving SHIFT.
        if (idx_q == CNT_W'(WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        if (bus.m_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pure state decodes so the detector sees glitch-free clear and data.
  always_comb begin
    bus.s_ready = (state_q == StIdle);
    bus.m_valid = (state_q == StDone);
    det_clr     = (state_q != StShift);
    det_bit     = (state_q == StShift) && shreg_q[WIDTH-1];
    bus.m_count = count_q;
    bus.m_first = first_q;
    bus.m_none  = ~seen_q;
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic det_clr, det_bit, det_hit;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();

  seq_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .det_clr (det_clr),
    .det_bit (det_bit),
    .det_hit (det_hit)
  );

  // 101/110 Mealy detector load; after a 110 hit it restarts from the empty state.
  localparam logic [1:0] DS0 = 2'd0, DS1 = 2'd1, DS10 = 2'd2, DS11 = 2'd3;
  logic [1:0] det_st;
  always @(posedge clk) begin
    if (rst | det_clr) det_st <= DS0;
    else begin
      case (det_st)
        DS0:     det_st <= det_bit ? DS1  : DS0;
        DS1:     det_st <= det_bit ? DS11 : DS10;
        DS10:    det_st <= det_bit ? DS1  : DS0;
        default: det_st <= det_bit ? DS11 : DS0;
      endcase
    end
  end
  assign det_hit = ((det_st == DS10) && det_bit) || ((det_st == DS11) && !det_bit);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one word, check the serial stream, and wait for m_valid (bounded).
  task automatic scan_word(input logic [7:0] d);
    int n;
    @(negedge clk);
    check("s_ready_before_accept", bus.s_ready, 1);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (bus.m_valid) break;
      if (n <= 8) begin
        check("det_bit_stream", det_bit, d[8-n]);
        check("det_clr_shift", det_clr, 0);
        check("s_ready_shift", bus.s_ready, 0);
      end
    end
    check("result_latency", n, 9);
  endtask

  task automatic check_result(input string tag, input int cnt, input int first, input bit none);
    check({tag, "_valid"}, bus.m_valid, 1);
    check({tag, "_count"}, bus.m_count, cnt);
    check({tag, "_first"}, bus.m_first, first);
    check({tag, "_none"}, bus.m_none, none);
    check({tag, "_det_clr"}, det_clr, 1);
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1 bus.m_ready = 1'b0;
    @(negedge clk);
    check("idle_after_ready", bus.s_ready, 1);
    check("mvalid_after_ready", bus.m_valid, 0);
  endtask

  initial begin
    logic [7:0] words [3];
    int         exp_cnt [3];
    int         k, r, cyc, last, seen_valid;

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_det_clr", det_clr, 1);
    check("rst_det_bit", det_bit, 0);
    check("rst_m_count", bus.m_count, 0);
    check("rst_m_first", bus.m_first, 0);
    check("rst_m_none", bus.m_none, 1);

    // 1010_1100: hits at 2,4,6
    scan_word(8'b1010_1100);
    check_result("w_ac", 3, 2, 0);
    release_result();
    check("hold_count_after_hs", bus.m_count, 3);
    check("hold_first_after_hs", bus.m_first, 2);

    // 0x6D: hits at 3,6
    scan_word(8'h6D);
    check_result("w_6d", 2, 3, 0);
    release_result();

    // FF leaves the detector in 11; 00 would hit at idx 0 without the clear
    scan_word(8'hFF);
    check_result("w_ff", 0, 0, 1);
    release_result();
    scan_word(8'h00);
    check_result("w_00", 0, 0, 1);
    release_result();

    // Backpressure: 5 stalled cycles in DONE
    scan_word(8'hAC);
    repeat (5) begin
      @(negedge clk);
      check("stall_m_valid", bus.m_valid, 1);
      check("stall_count", bus.m_count, 3);
      check("stall_first", bus.m_first, 2);
      check("stall_none", bus.m_none, 0);
      check("stall_s_ready", bus.s_ready, 0);
      check("stall_det_clr", det_clr, 1);
    end
    release_result();

    // Reset during the 4th SHIFT cycle aborts the word
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h6D;
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_s_ready", bus.s_ready, 1);
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_m_none", bus.m_none, 1);
    check("abort_det_clr", det_clr, 1);
    seen_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.m_valid) seen_valid++;
    end
    check("abort_no_result", seen_valid, 0);
    scan_word(8'hAC);
    check_result("post_abort", 3, 2, 0);
    release_result();

    // Throughput: s_valid held, m_ready held
    words[0] = 8'hAC; words[1] = 8'h6D; words[2] = 8'hFF;
    exp_cnt[0] = 3;   exp_cnt[1] = 2;   exp_cnt[2] = 0;
    k = 0; r = 0; cyc = 0; last = -1;
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = words[0];
    while ((k < 3 || r < 3) && cyc < 100) begin
      if (bus.m_valid && r < 3) begin
        check("tput_count", bus.m_count, exp_cnt[r]);
        r++;
      end
      if (bus.s_ready) begin
        if (k < 3) begin
          if (last >= 0) check("tput_spacing", cyc - last, 10);
          last = cyc;
          bus.s_data = words[k];
          k++;
        end else begin
          bus.s_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    check("tput_words_accepted", k, 3);
    check("tput_results_seen", r, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
